// File: rtl/reg_file_2r1w_pkg.sv
// Shared defaults and clear-engine state encoding for the 2R1W register file.
package reg_file_2r1w_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

endpackage

// File: rtl/reg_word_pp.sv
// One storage word: load-enabled register with async reset to a preset pattern.
module reg_word_pp
    import reg_file_2r1w_pkg::*;
#(
    parameter int               WIDTH   = DATA_WIDTH_DEF,
    parameter logic [WIDTH-1:0] PATTERN = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] word_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            word_q <= PATTERN;
        else if (ld_i)
            word_q <= d_i;
    end

    assign q_o = word_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// Two-read/one-write register bank with registered write-first reads,
// optional hardwired-zero r0 and a one-word-per-cycle bulk-clear sweep.
module reg_file_2r1w
    import reg_file_2r1w_pkg::*;
#(
    parameter int          DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int          ADDR_WIDTH    = ADDR_WIDTH_DEF,
    parameter logic [31:0] RESET_PATTERN = 32'h0000_0000,
    parameter bit          ZERO_REG0     = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDR_W,
    input  logic [DATA_WIDTH-1:0] DATA_W,
    input  logic [ADDR_WIDTH-1:0] ADDR_R1,
    input  logic [ADDR_WIDTH-1:0] ADDR_R2,
    output logic [DATA_WIDTH-1:0] DATA_R1,
    output logic [DATA_WIDTH-1:0] DATA_R2,
    input  logic                  CLEAR,
    output logic                  BUSY,
    output logic                  WR_DROP
);

    localparam int                    DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [DATA_WIDTH-1:0] PAT   = DATA_WIDTH'(RESET_PATTERN);
    localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(DEPTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
    logic                  drop_q, drop_d;

    logic                  busy, wr_acc;
    logic [DEPTH-1:0]      ld;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] word [DEPTH];

    assign busy   = (state_q == SWEEP);
    assign wr_acc = WRITE && !busy && !(ZERO_REG0 && ADDR_W == '0);
    assign wdata  = busy ? PAT : DATA_W;

    // The sweep counter owns the write decode while busy; host writes are shut out.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        assign ld[i] = busy ? (cnt_q == ADDR_WIDTH'(i))
                            : (wr_acc && ADDR_W == ADDR_WIDTH'(i));
        reg_word_pp #(
            .WIDTH  (DATA_WIDTH),
            .PATTERN(PAT)
        ) u_word (
            .clk_i(CLK),
            .rst_i(RESET),
            .ld_i (ld[i]),
            .d_i  (wdata),
            .q_o  (word[i])
        );
    end

    // Zero-register masking wins over bypass, bypass wins over storage.
    always_comb begin
        rd1_d = word[ADDR_R1];
        rd2_d = word[ADDR_R2];
        if (wr_acc && ADDR_R1 == ADDR_W) rd1_d = DATA_W;
        if (wr_acc && ADDR_R2 == ADDR_W) rd2_d = DATA_W;
        if (ZERO_REG0 && ADDR_R1 == '0)  rd1_d = '0;
        if (ZERO_REG0 && ADDR_R2 == '0)  rd2_d = '0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drop_d  = WRITE && busy;
        case (state_q)
            IDLE: begin
                if (CLEAR) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            drop_q  <= drop_d;
        end
    end

    assign DATA_R1 = rd1_q;
    assign DATA_R2 = rd2_q;
    assign BUSY    = busy;
    assign WR_DROP = drop_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed checks on 32x32 banks (r0 plain and r0 hardwired) plus a
// randomised run on an 8x16 bank against a small reference array.
module tb_reg_file_2r1w;

    localparam logic [31:0] PAT   = 32'hA5A5_A5A5;
    localparam logic [15:0] PAT16 = 16'hBEEF;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        WRITE, CLEAR;
    logic [4:0]  ADDR_W, ADDR_R1, ADDR_R2;
    logic [31:0] DATA_W;
    logic [31:0] r1, r2, z1, z2;
    logic        busy, drop, zbusy, zdrop;

    logic        w16;
    logic [2:0]  aw16, ar1_16, ar2_16;
    logic [15:0] dw16, r1_16, r2_16;
    logic        busy16, drop16;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    reg_file_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .RESET_PATTERN(PAT), .ZERO_REG0(1'b0)) u_dut (
        .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .ADDR_R1(ADDR_R1), .ADDR_R2(ADDR_R2), .DATA_R1(r1), .DATA_R2(r2),
        .CLEAR(CLEAR), .BUSY(busy), .WR_DROP(drop));

    reg_file_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .RESET_PATTERN(PAT), .ZERO_REG0(1'b1)) u_dutz (
        .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .ADDR_R1(ADDR_R1), .ADDR_R2(ADDR_R2), .DATA_R1(z1), .DATA_R2(z2),
        .CLEAR(CLEAR), .BUSY(zbusy), .WR_DROP(zdrop));

    reg_file_2r1w #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .RESET_PATTERN({16'h0, PAT16}), .ZERO_REG0(1'b1)) u_dut16 (
        .CLK(CLK), .RESET(RESET), .WRITE(w16), .ADDR_W(aw16), .DATA_W(dw16),
        .ADDR_R1(ar1_16), .ADDR_R2(ar2_16), .DATA_R1(r1_16), .DATA_R2(r2_16),
        .CLEAR(1'b0), .BUSY(busy16), .WR_DROP(drop16));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    logic [15:0] mem16 [8];
    logic [15:0] e1, e2;
    int          bc, guard;

    initial begin
        RESET = 1'b1; WRITE = 1'b0; CLEAR = 1'b0;
        ADDR_W = '0; ADDR_R1 = '0; ADDR_R2 = '0; DATA_W = '0;
        w16 = 1'b0; aw16 = '0; ar1_16 = '0; ar2_16 = '0; dw16 = '0;
        #12;
        chk("rst_r1", r1, 32'h0);
        chk("rst_r2", r2, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_drop", {31'h0, drop}, 32'h0);
        @(negedge CLK);
        RESET = 1'b0;

        // reset contents
        ADDR_R1 = 5'd7; ADDR_R2 = 5'd0;
        step();
        chk("init_r1_a7", r1, PAT);
        chk("init_r2_a0", r2, PAT);
        chk("init_z_a0", z2, 32'h0);
        chk("init_busy", {31'h0, busy}, 32'h0);
        chk("init_drop", {31'h0, drop}, 32'h0);

        // write then read
        WRITE = 1'b1; ADDR_W = 5'd3; DATA_W = 32'hDEAD_BEEF;
        step();
        WRITE = 1'b0; ADDR_R1 = 5'd3;
        step();
        chk("wr_rd_a3", r1, 32'hDEAD_BEEF);

        // bypass on both ports
        WRITE = 1'b1; DATA_W = 32'h1234_5678; ADDR_R2 = 5'd3;
        step();
        chk("byp_r1", r1, 32'h1234_5678);
        chk("byp_r2", r2, 32'h1234_5678);
        WRITE = 1'b0;
        step();
        chk("byp_stored", r1, 32'h1234_5678);

        // register 0: plain storage vs hardwired zero
        WRITE = 1'b1; ADDR_W = 5'd0; DATA_W = 32'hFFFF_FFFF; ADDR_R1 = 5'd0; ADDR_R2 = 5'd0;
        step();
        chk("r0_plain_byp", r1, 32'hFFFF_FFFF);
        chk("r0_zero_byp1", z1, 32'h0);
        chk("r0_zero_byp2", z2, 32'h0);
        WRITE = 1'b0;
        step();
        chk("r0_plain_hold", r1, 32'hFFFF_FFFF);
        chk("r0_zero_hold1", z1, 32'h0);
        chk("r0_zero_hold2", z2, 32'h0);

        // fill 1..31 with index
        for (int a = 1; a < 32; a++) begin
            WRITE = 1'b1; ADDR_W = 5'(a); DATA_W = 32'(a);
            step();
        end
        WRITE = 1'b0; ADDR_R1 = 5'd17; ADDR_R2 = 5'd31;
        step();
        chk("fill_a17", r1, 32'd17);
        chk("fill_a31", r2, 32'd31);

        // clear sweep with re-CLEAR, dropped write and live reads
        CLEAR = 1'b1;
        step();
        CLEAR = 1'b0;
        chk("clr_busy_on", {31'h0, busy}, 32'h1);
        bc = 1; guard = 0;
        while (busy && guard < 40) begin
            CLEAR   = (bc == 5);
            WRITE   = (bc == 8);
            ADDR_W  = 5'd30; DATA_W = 32'h55;
            ADDR_R1 = 5'd31;
            step();
            guard++;
            if (bc == 3) chk("sweep_live_rd", r1, 32'd31);
            if (bc == 8) chk("wrdrop_pulse", {31'h0, drop}, 32'h1);
            if (bc == 9) chk("wrdrop_clear", {31'h0, drop}, 32'h0);
            if (busy) bc++;
        end
        CLEAR = 1'b0; WRITE = 1'b0;
        chk("busy_len", 32'(bc), 32'd32);
        for (int a = 0; a < 32; a++) begin
            ADDR_R1 = 5'(a);
            step();
            chk($sformatf("post_clr_a%0d", a), r1, PAT);
        end
        chk("post_clr_drop", {31'h0, drop}, 32'h0);

        // reset mid-sweep
        WRITE = 1'b1; ADDR_W = 5'd25; DATA_W = 32'h77;
        step();
        WRITE = 1'b0; CLEAR = 1'b1; ADDR_R1 = 5'd25;
        step();
        CLEAR = 1'b0;
        for (int k = 0; k < 10; k++) step();
        chk("pre_rst_busy", {31'h0, busy}, 32'h1);
        chk("pre_rst_rd25", r1, 32'h77);
        #2 RESET = 1'b1;
        #1;
        chk("async_rst_busy", {31'h0, busy}, 32'h0);
        chk("async_rst_r1", r1, 32'h0);
        chk("async_rst_drop", {31'h0, drop}, 32'h0);
        @(negedge CLK);
        RESET = 1'b0;
        step();
        chk("rst_rd25", r1, PAT);
        chk("rst_idle", {31'h0, busy}, 32'h0);

        // randomised 8x16 run
        for (int a = 0; a < 8; a++) mem16[a] = PAT16;
        for (int c = 0; c < 2000; c++) begin
            w16    = 1'($urandom_range(0, 1));
            aw16   = 3'($urandom_range(0, 7));
            dw16   = 16'($urandom);
            ar1_16 = ($urandom_range(0, 3) == 0) ? aw16 : 3'($urandom_range(0, 7));
            ar2_16 = ($urandom_range(0, 3) == 0) ? ar1_16 : 3'($urandom_range(0, 7));
            e1 = (ar1_16 == 3'd0) ? 16'h0 : (w16 && aw16 != 3'd0 && aw16 == ar1_16) ? dw16 : mem16[ar1_16];
            e2 = (ar2_16 == 3'd0) ? 16'h0 : (w16 && aw16 != 3'd0 && aw16 == ar2_16) ? dw16 : mem16[ar2_16];
            if (w16 && aw16 != 3'd0) mem16[aw16] = dw16;
            step();
            chk($sformatf("rnd_r1_c%0d", c), {16'h0, r1_16}, {16'h0, e1});
            chk($sformatf("rnd_r2_c%0d", c), {16'h0, r2_16}, {16'h0, e2});
        end
        w16 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
